// File: rtl/rng_sampler.sv
// ============================================================================
// rng_sampler
//
// Turns the free-running 32-bit LFSR state into uniformly distributed samples
// in [0, range_i) using mask-and-reject sampling. Accepted samples are queued
// in a small first-word-fall-through FIFO that drains over valid/ready.
//
// Optional build macro:
//   RNG_SAMPLER_WHITEN_EN - XOR-fold the top WIDTH bits of the LFSR state onto
//                           the low WIDTH bits before masking.
//
// Parameters:
//   WIDTH  sample width in bits (2..16)
//   DEPTH  FIFO entries (power of two, 2..16)
//   CNT_W  width of the saturating rejection counter
//
// Ports:
//   clk_i          system clock, all state on rising edge
//   reset_i        asynchronous active-high reset
//   enable_i       sampling enable; low = no new samples taken
//   lfsr_state_i   LFSR state, new value every cycle
//   range_i        exclusive upper bound; 0 = full 2^WIDTH range
//   sample_o       FIFO head sample (0 while empty)
//   sample_valid_o FIFO non-empty
//   sample_ready_i consumer accepts head when valid & ready
//   fifo_level_o   current FIFO occupancy
//   reject_cnt_o   saturating count of rejected candidates
// ============================================================================
module rng_sampler #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic [31:0]              lfsr_state_i,
    input  logic [WIDTH-1:0]         range_i,
    output logic [WIDTH-1:0]         sample_o,
    output logic                     sample_valid_o,
    input  logic                     sample_ready_i,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic [CNT_W-1:0]         reject_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   range_q_reg;
    logic               range_load;

    logic [WIDTH-1:0]   fifo_mem [DEPTH];
    logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]      level_reg;
    logic [CNT_W-1:0]   reject_cnt_reg;

    logic [WIDTH-1:0]   range_m1;
    logic [WIDTH-1:0]   mask;
    logic [WIDTH-1:0]   cand_raw;
    logic [WIDTH-1:0]   cand;
    logic               accept;
    logic               range_changed;
    logic               take;
    logic               fifo_full, fifo_empty;
    logic               push, pop, fifo_clear, reject_inc;
    logic               unused_lfsr;

    // ------------------------------------------------------------------------
    // Mask: all ones from the MSB of (range_q - 1) downward, bit 0 always set.
    // range_q = 0 wraps range_m1 to all ones, giving the full-width mask, and
    // range_q = 1 gives mask 1, so both corner cases fall out of one formula.
    // ------------------------------------------------------------------------
    assign range_m1 = range_q_reg - WIDTH'(1);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mask
            if (gi == 0) begin : g_lsb
                assign mask[gi] = 1'b1;
            end else begin : g_upper
                assign mask[gi] = |range_m1[WIDTH-1:gi];
            end
        end
    endgenerate

`ifdef RNG_SAMPLER_WHITEN_EN
    assign cand_raw = lfsr_state_i[WIDTH-1:0] ^ lfsr_state_i[31:32-WIDTH];
`else
    assign cand_raw = lfsr_state_i[WIDTH-1:0];
`endif

    // Not every LFSR bit feeds the candidate; fold them so nothing dangles.
    assign unused_lfsr = ^lfsr_state_i;

    assign cand   = cand_raw & mask;
    // With range_q = 1 the compare reduces to cand == 0.
    assign accept = (range_q_reg == '0) || (cand < range_q_reg);

    assign range_changed = (range_i != range_q_reg);

    // A candidate is only judged in RUN while enabled and while the range is
    // stable; a range change turns the cycle into the entry to FLUSH instead.
    assign take = (state_reg == ST_RUN) && enable_i && !range_changed;

    assign fifo_full  = (level_reg == LW'(DEPTH));
    assign fifo_empty = (level_reg == '0);

    // Clear on the edge entering FLUSH so the FLUSH cycle itself already shows
    // an empty FIFO (and any pop request there has nothing to take).
    assign fifo_clear = ((state_reg == ST_RUN) && enable_i && range_changed) ||
                        (state_reg == ST_FLUSH);

    assign pop        = !fifo_empty && sample_ready_i && (state_reg != ST_FLUSH);
    assign push       = take && accept && (!fifo_full || pop);
    // Accepted-but-dropped samples (full FIFO, no pop) are not rejects.
    assign reject_inc = take && !accept;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        range_load = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (enable_i) begin
                    state_next = ST_RUN;
                    range_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable_i) begin
                    state_next = ST_IDLE;
                end else if (range_changed) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                range_load = 1'b1;
                state_next = enable_i ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg   <= ST_IDLE;
            range_q_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (range_load) begin
                range_q_reg <= range_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage: plain array, written on push, read combinationally at the
    // head for first-word-fall-through behaviour.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= cand;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (fifo_clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Saturating rejection counter; survives FLUSH and IDLE.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            reject_cnt_reg <= '0;
        end else if (reject_inc && (reject_cnt_reg != '1)) begin
            reject_cnt_reg <= reject_cnt_reg + CNT_W'(1);
        end
    end

    assign sample_o       = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
    assign sample_valid_o = !fifo_empty;
    assign fifo_level_o   = level_reg;
    assign reject_cnt_o   = reject_cnt_reg;

endmodule

// File: tb/tb_rng_sampler.sv
// ============================================================================
// tb_rng_sampler
//
// Directed, self-checking bench for rng_sampler (WIDTH=8, DEPTH=4, CNT_W=16).
// Each task drives one scenario and compares outputs against hand-computed
// values, sampling 1 time unit after the rising edge.
// ============================================================================
`timescale 1ns/1ps
module tb_rng_sampler;

    logic        clk_i;
    logic        reset_i;
    logic        enable_i;
    logic [31:0] lfsr_state_i;
    logic [7:0]  range_i;
    logic [7:0]  sample_o;
    logic        sample_valid_o;
    logic        sample_ready_i;
    logic [2:0]  fifo_level_o;
    logic [15:0] reject_cnt_o;

    int checks;
    int failures;

    rng_sampler #(
        .WIDTH (8),
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .enable_i       (enable_i),
        .lfsr_state_i   (lfsr_state_i),
        .range_i        (range_i),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .fifo_level_o   (fifo_level_o),
        .reject_cnt_o   (reject_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (2) step();
        checks++;
        if (sample_valid_o !== 1'b0 || fifo_level_o !== 3'd0 ||
            sample_o !== 8'h00 || reject_cnt_o !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state: valid=%0b level=%0d sample=%0h rej=%0h, want 0/0/0/0",
                     sample_valid_o, fifo_level_o, sample_o, reject_cnt_o);
        end
        reset_i = 1'b0;
        step();
        $display("reset: level=%0d valid=%0b", fifo_level_o, sample_valid_o);
    endtask

    task automatic test_basic();
        range_i      = 8'd200;
        lfsr_state_i = 32'h00BDF3A0;
        enable_i     = 1'b1;
        step();                       // IDLE -> RUN
        checks++;
        if (sample_valid_o !== 1'b0 || fifo_level_o !== 3'd0) begin
            failures++;
            $display("FAIL basic_enter_run: valid=%0b level=%0d, want 0/0",
                     sample_valid_o, fifo_level_o);
        end
        step();                       // 0xA0 pushed
        checks++;
        if (sample_valid_o !== 1'b1 || sample_o !== 8'hA0 || fifo_level_o !== 3'd1) begin
            failures++;
            $display("FAIL basic_first_sample: valid=%0b sample=%0h level=%0d, want 1/a0/1",
                     sample_valid_o, sample_o, fifo_level_o);
        end
        $display("basic: first sample=%0h", sample_o);
        repeat (4) step();            // fills to 4, then one dropped push
        checks++;
        if (fifo_level_o !== 3'd4 || reject_cnt_o !== 16'd0 || sample_o !== 8'hA0) begin
            failures++;
            $display("FAIL basic_full: level=%0d rej=%0d sample=%0h, want 4/0/a0",
                     fifo_level_o, reject_cnt_o, sample_o);
        end
        $display("basic: level=%0d rej=%0d", fifo_level_o, reject_cnt_o);
    endtask

    task automatic test_reject();
        range_i      = 8'd100;        // mask 0x7F
        lfsr_state_i = 32'h00000070;  // 112 >= 100
        step();                       // RUN -> FLUSH
        checks++;
        if (fifo_level_o !== 3'd0 || sample_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reject_flush: level=%0d valid=%0b, want 0/0",
                     fifo_level_o, sample_valid_o);
        end
        step();                       // FLUSH -> RUN, range_q = 100
        repeat (3) step();
        checks++;
        if (reject_cnt_o !== 16'd3 || fifo_level_o !== 3'd0) begin
            failures++;
            $display("FAIL reject_count: rej=%0d level=%0d, want 3/0",
                     reject_cnt_o, fifo_level_o);
        end
        $display("reject: rej=%0d", reject_cnt_o);
        lfsr_state_i = 32'h00000005;
        step();
        checks++;
        if (sample_valid_o !== 1'b1 || sample_o !== 8'd5 ||
            fifo_level_o !== 3'd1 || reject_cnt_o !== 16'd3) begin
            failures++;
            $display("FAIL reject_then_accept: valid=%0b sample=%0d level=%0d rej=%0d, want 1/5/1/3",
                     sample_valid_o, sample_o, fifo_level_o, reject_cnt_o);
        end
    endtask

    task automatic test_full_stream();
        logic [7:0] want;
        repeat (3) step();            // FIFO = 5,5,5,5
        checks++;
        if (fifo_level_o !== 3'd4) begin
            failures++;
            $display("FAIL stream_fill: level=%0d, want 4", fifo_level_o);
        end
        sample_ready_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            lfsr_state_i = k;
            step();
            want = (k < 4) ? 8'd5 : 8'(k - 3);
            $display("stream: k=%0d head=%0d level=%0d", k, sample_o, fifo_level_o);
            checks++;
            if (fifo_level_o !== 3'd4 || sample_o !== want) begin
                failures++;
                $display("FAIL stream_k%0d: level=%0d head=%0d, want 4/%0d",
                         k, fifo_level_o, sample_o, want);
            end
        end
        sample_ready_i = 1'b0;
    endtask

    task automatic test_flush();
        range_i      = 8'd200;
        lfsr_state_i = 32'h0000000A;
        step();                       // RUN -> FLUSH
        step();                       // FLUSH -> RUN (200)
        repeat (3) step();            // three pushes of 10
        checks++;
        if (fifo_level_o !== 3'd3 || sample_o !== 8'd10) begin
            failures++;
            $display("FAIL flush_setup: level=%0d sample=%0d, want 3/10",
                     fifo_level_o, sample_o);
        end
        range_i      = 8'd50;         // mask 0x3F
        lfsr_state_i = 32'h0000003C;  // 60 >= 50
        step();                       // in FLUSH
        checks++;
        if (sample_valid_o !== 1'b0 || fifo_level_o !== 3'd0 || sample_o !== 8'd0) begin
            failures++;
            $display("FAIL flush_cycle: valid=%0b level=%0d sample=%0d, want 0/0/0",
                     sample_valid_o, fifo_level_o, sample_o);
        end
        step();                       // back in RUN with range_q = 50
        checks++;
        if (reject_cnt_o !== 16'd3) begin
            failures++;
            $display("FAIL flush_rej_kept: rej=%0d, want 3", reject_cnt_o);
        end
        step();                       // 60 rejected under range 50
        checks++;
        if (reject_cnt_o !== 16'd4 || fifo_level_o !== 3'd0) begin
            failures++;
            $display("FAIL flush_new_range_reject: rej=%0d level=%0d, want 4/0",
                     reject_cnt_o, fifo_level_o);
        end
        lfsr_state_i = 32'h00000071;  // 0x71 & 0x3F = 49
        step();
        checks++;
        if (sample_o !== 8'd49 || fifo_level_o !== 3'd1) begin
            failures++;
            $display("FAIL flush_mask63: sample=%0d level=%0d, want 49/1",
                     sample_o, fifo_level_o);
        end
        $display("flush: sample=%0d rej=%0d", sample_o, reject_cnt_o);
    endtask

    task automatic test_back_to_back();
        sample_ready_i = 1'b1;
        lfsr_state_i   = 32'h00000007;
        step();                       // pop 49, push 7
        checks++;
        if (fifo_level_o !== 3'd1 || sample_o !== 8'd7) begin
            failures++;
            $display("FAIL b2b_swap: level=%0d sample=%0d, want 1/7",
                     fifo_level_o, sample_o);
        end
        lfsr_state_i = 32'h0000003C;
        step();                       // pop 7, reject
        checks++;
        if (fifo_level_o !== 3'd0 || sample_valid_o !== 1'b0 || reject_cnt_o !== 16'd5) begin
            failures++;
            $display("FAIL b2b_drain: level=%0d valid=%0b rej=%0d, want 0/0/5",
                     fifo_level_o, sample_valid_o, reject_cnt_o);
        end
        lfsr_state_i = 32'h00000009;
        step();                       // push into empty FIFO while ready=1
        checks++;
        if (fifo_level_o !== 3'd1 || sample_o !== 8'd9 || sample_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_empty_push: level=%0d sample=%0d valid=%0b, want 1/9/1",
                     fifo_level_o, sample_o, sample_valid_o);
        end
        sample_ready_i = 1'b0;
        $display("b2b: level=%0d head=%0d", fifo_level_o, sample_o);
    endtask

    task automatic test_enable_low();
        enable_i     = 1'b0;
        lfsr_state_i = 32'h00000003;
        repeat (2) step();            // RUN -> IDLE, contents retained
        checks++;
        if (fifo_level_o !== 3'd1 || sample_o !== 8'd9) begin
            failures++;
            $display("FAIL idle_retain: level=%0d sample=%0d, want 1/9",
                     fifo_level_o, sample_o);
        end
        sample_ready_i = 1'b1;
        step();
        checks++;
        if (fifo_level_o !== 3'd0 || sample_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_drain: level=%0d valid=%0b, want 0/0",
                     fifo_level_o, sample_valid_o);
        end
        sample_ready_i = 1'b0;
        $display("idle: level=%0d", fifo_level_o);
    endtask

    task automatic test_saturate_and_reset();
        enable_i     = 1'b1;
        lfsr_state_i = 32'h0000003C;  // rejected under range 50
        step();                       // IDLE -> RUN
        repeat (65541) step();
        checks++;
        if (reject_cnt_o !== 16'hFFFF) begin
            failures++;
            $display("FAIL saturate: rej=%0h, want ffff", reject_cnt_o);
        end
        $display("saturate: rej=%0h", reject_cnt_o);
        lfsr_state_i = 32'h00000009;
        repeat (2) step();
        checks++;
        if (fifo_level_o !== 3'd2 || reject_cnt_o !== 16'hFFFF) begin
            failures++;
            $display("FAIL presreset_fill: level=%0d rej=%0h, want 2/ffff",
                     fifo_level_o, reject_cnt_o);
        end
        #2 reset_i = 1'b1;            // between edges
        #1;
        checks++;
        if (sample_valid_o !== 1'b0 || fifo_level_o !== 3'd0 ||
            sample_o !== 8'h00 || reject_cnt_o !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset: valid=%0b level=%0d sample=%0h rej=%0h, want 0/0/0/0",
                     sample_valid_o, fifo_level_o, sample_o, reject_cnt_o);
        end
        $display("async reset: level=%0d rej=%0h", fifo_level_o, reject_cnt_o);
        enable_i = 1'b0;
        step();
        reset_i = 1'b0;
        step();
    endtask

    task automatic test_whiten();
        logic [7:0] want;
`ifdef RNG_SAMPLER_WHITEN_EN
        want = 8'hFF;                 // 0xA5 ^ 0x5A
`else
        want = 8'hA5;
`endif
        range_i      = 8'd0;          // full range, always accept
        lfsr_state_i = 32'h5A0000A5;
        enable_i     = 1'b1;
        step();                       // IDLE -> RUN
        step();
        checks++;
        if (sample_valid_o !== 1'b1 || sample_o !== want || fifo_level_o !== 3'd1) begin
            failures++;
            $display("FAIL whiten_full_range: valid=%0b sample=%0h level=%0d, want 1/%0h/1",
                     sample_valid_o, sample_o, fifo_level_o, want);
        end
        $display("whiten: sample=%0h", sample_o);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset_i        = 1'b1;
        enable_i       = 1'b0;
        lfsr_state_i   = 32'h0;
        range_i        = 8'd0;
        sample_ready_i = 1'b0;

        test_reset();
        test_basic();
        test_reject();
        test_full_stream();
        test_flush();
        test_back_to_back();
        test_enable_low();
        test_saturate_and_reset();
        test_whiten();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
